// File: rtl/post_switch_ctrl_if.sv
// post_switch_ctrl_if: groups the host command, traffic monitor and status signals of
// post_switch_ctrl.
//   master : host/environment side (drives commands and observed data-valids)
//   slave  : controller side (drives select and status pulses)
// Signals:
//   cmd_valid, cmd_sel     one-cycle switch command and requested path
//   auto_en                failover enable
//   down_dv                post_switch output data-valid
//   path0_dv, path1_dv     raw upstream data-valids
//   select, pending        current path and switch-in-progress flag
//   switch_done, failover  one-cycle event pulses
interface post_switch_ctrl_if;
  logic cmd_valid;
  logic cmd_sel;
  logic auto_en;
  logic down_dv;
  logic path0_dv;
  logic path1_dv;
  logic select;
  logic pending;
  logic switch_done;
  logic failover;

  modport master (
    output cmd_valid, cmd_sel, auto_en, down_dv, path0_dv, path1_dv,
    input  select, pending, switch_done, failover
  );

  modport slave (
    input  cmd_valid, cmd_sel, auto_en, down_dv, path0_dv, path1_dv,
    output select, pending, switch_done, failover
  );
endinterface

// File: rtl/post_switch_ctrl.sv
// post_switch_ctrl: owns post_switch.select and moves it only after the downstream side has
// been idle for IPG_CYCLES, so frames are never truncated or spliced. A hold-off window
// follows every switch.
// Optional watchdog failover, compiled in with `define POST_SWITCH_FAILOVER_EN: when the
// active path has been silent for TIMEOUT cycles while the other path showed traffic, a
// switch is requested automatically (pulse on failover).
// Ports:
//   clk    GMII-side clock
//   rst    asynchronous active-high reset
//   sw_io  post_switch_ctrl_if.slave (commands, data-valids, select and status outputs)
module post_switch_ctrl #(
  parameter int unsigned IPG_CYCLES = 12,
  parameter int unsigned HOLDOFF    = 64,
  parameter int unsigned TIMEOUT    = 125000,
  parameter int unsigned TIMEOUT_W  = 20
) (
  input logic               clk,
  input logic               rst,
  post_switch_ctrl_if.slave sw_io
);

  typedef enum logic [1:0] {StLocked, StPending, StHoldoff} state_e;

  localparam logic [7:0]  IpgMax   = 8'(IPG_CYCLES);
  localparam logic [15:0] HoldLast = 16'(HOLDOFF - 1);

  state_e      state_q, state_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] hold_q, hold_d;
  logic        target_q, target_d;
  logic        flag_q, flag_d;
  logic        select_q, select_d;
  logic        pending_q, pending_d;
  logic        done_q, done_d;
  logic        fo_q, fo_d;
  logic        gap_full;
  logic        do_switch;
  logic        wd_fire;
  logic        ho_go;

  assign gap_full = (gap_q == IpgMax) && !sw_io.down_dv;

`ifdef POST_SWITCH_FAILOVER_EN
  localparam logic [TIMEOUT_W-1:0] IdleMax = TIMEOUT_W'(TIMEOUT);

  logic [TIMEOUT_W-1:0] idle_q, idle_d;
  logic                 alt_q, alt_d;
  logic                 p0_q, p1_q;
  logic                 act_rise, alt_rise;

  assign act_rise = select_q ? (sw_io.path1_dv & ~p1_q) : (sw_io.path0_dv & ~p0_q);
  assign alt_rise = select_q ? (sw_io.path0_dv & ~p0_q) : (sw_io.path1_dv & ~p1_q);
  assign wd_fire  = sw_io.auto_en && (idle_q == IdleMax) && alt_q;

  always_comb begin
    idle_d = idle_q;
    alt_d  = alt_q;
    if (do_switch || act_rise) begin
      idle_d = '0;
      alt_d  = 1'b0;
    end else begin
      if (idle_q != IdleMax) idle_d = idle_q + TIMEOUT_W'(1);
      if (alt_rise) alt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
      alt_q  <= 1'b0;
      p0_q   <= 1'b0;
      p1_q   <= 1'b0;
    end else begin
      idle_q <= idle_d;
      alt_q  <= alt_d;
      p0_q   <= sw_io.path0_dv;
      p1_q   <= sw_io.path1_dv;
    end
  end
`else
  logic unused_wd;
  assign unused_wd = ^{sw_io.auto_en, sw_io.path0_dv, sw_io.path1_dv};
  assign wd_fire   = 1'b0;
`endif

  // Idle-gap counter runs in every state; a switch restarts it.
  always_comb begin
    if (sw_io.down_dv || do_switch) gap_d = '0;
    else if (gap_q == IpgMax)        gap_d = gap_q;
    else                             gap_d = gap_q + 8'd1;
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    flag_d    = flag_q;
    hold_d    = hold_q;
    select_d  = select_q;
    done_d    = 1'b0;
    fo_d      = 1'b0;
    do_switch = 1'b0;
    ho_go     = 1'b0;
    unique case (state_q)
      StLocked: begin
        // A command takes priority over the watchdog.
        if (sw_io.cmd_valid) begin
          if (sw_io.cmd_sel != select_q) begin
            target_d = sw_io.cmd_sel;
            state_d  = StPending;
          end
        end else if (wd_fire) begin
          fo_d     = 1'b1;
          target_d = ~select_q;
          state_d  = StPending;
        end
      end
      StPending: begin
        // Command evaluated first: a cancel suppresses a same-cycle switch.
        if (sw_io.cmd_valid) target_d = sw_io.cmd_sel;
        if (target_d == select_q) state_d = StLocked;
        else if (gap_full)        do_switch = 1'b1;
      end
      StHoldoff: begin
        hold_d = hold_q + 16'd1;
        if (sw_io.cmd_valid) begin
          target_d = sw_io.cmd_sel;
          if (sw_io.cmd_sel != select_q) flag_d = 1'b1;
        end
        if (hold_q == HoldLast) begin
          ho_go   = flag_d && (target_d != select_q);
          hold_d  = '0;
          flag_d  = 1'b0;
          state_d = ho_go ? StPending : StLocked;
        end
      end
      default: state_d = StLocked;
    endcase
    if (do_switch) begin
      select_d = target_d;
      done_d   = 1'b1;
      hold_d   = '0;
      flag_d   = 1'b0;
      state_d  = StHoldoff;
    end
    pending_d = (state_d == StPending) || ((state_d == StHoldoff) && flag_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StLocked;
      gap_q     <= '0;
      hold_q    <= '0;
      target_q  <= 1'b0;
      flag_q    <= 1'b0;
      select_q  <= 1'b0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      fo_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      hold_q    <= hold_d;
      target_q  <= target_d;
      flag_q    <= flag_d;
      select_q  <= select_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      fo_q      <= fo_d;
    end
  end

  assign sw_io.select      = select_q;
  assign sw_io.pending     = pending_q;
  assign sw_io.switch_done = done_q;
  assign sw_io.failover    = fo_q;

endmodule

// File: tb/tb_post_switch_ctrl.sv
// tb_post_switch_ctrl: randomized and directed stimulus for post_switch_ctrl. A reference
// model works on edge timestamps (last busy edge, last switch edge, request edge) and
// pushes expected switch/failover events into queues; a negedge monitor compares them and
// the per-cycle select/pending levels.
module tb_post_switch_ctrl;
  localparam int IPG     = 12;
  localparam int HOLD    = 64;
  localparam int TMO     = 1000;
`ifdef POST_SWITCH_FAILOVER_EN
  localparam bit WdOn = 1'b1;
`else
  localparam bit WdOn = 1'b0;
`endif

  typedef struct {int e_n; logic sel;} ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  post_switch_ctrl_if ifc ();

  post_switch_ctrl #(
    .IPG_CYCLES(IPG),
    .HOLDOFF   (HOLD),
    .TIMEOUT   (TMO),
    .TIMEOUT_W (20)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .sw_io(ifc)
  );

  always #5 clk = ~clk;

  // Reference model state
  ev_t  sw_q[$];
  ev_t  fo_q[$];
  logic m_sel, target, ho_flag, req_prev, alt, p0_prev, p1_prev, m_pend;
  int   last_dv, last_sw, req_edge, w_ref;
  bit   in_hold, locked, sw, act_rise, alt_rise, req;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_sel = 0; target = 0; ho_flag = 0; req_prev = 0; alt = 0;
      p0_prev = 0; p1_prev = 0; m_pend = 0;
      last_dv = cyc; last_sw = -100000; req_edge = 0; w_ref = cyc;
      sw_q.delete();
      fo_q.delete();
    end else begin
      in_hold  = (cyc >= last_sw + 1) && (cyc <= last_sw + HOLD);
      locked   = !in_hold && (target == m_sel);
      sw       = 0;
      act_rise = m_sel ? (ifc.path1_dv && !p1_prev) : (ifc.path0_dv && !p0_prev);
      alt_rise = m_sel ? (ifc.path0_dv && !p0_prev) : (ifc.path1_dv && !p1_prev);
      if (ifc.down_dv) last_dv = cyc;
      if (ifc.cmd_valid) begin
        target = ifc.cmd_sel;
        if (in_hold && ifc.cmd_sel != m_sel) ho_flag = 1;
      end else if (WdOn && locked && ifc.auto_en && alt && (cyc - 1 - w_ref >= TMO)) begin
        target = !m_sel;
        fo_q.push_back('{cyc, 1'b1});
      end
      req = (target != m_sel);
      if (req && !req_prev) req_edge = cyc;
      if (req && cyc >= req_edge + 1 && cyc - last_dv >= IPG + 1 && cyc >= last_sw + HOLD + 1)
      begin
        m_sel = target; last_sw = cyc; w_ref = cyc; alt = 0; ho_flag = 0; sw = 1;
        sw_q.push_back('{cyc, m_sel});
      end
      if (!sw) begin
        if (act_rise) begin w_ref = cyc; alt = 0; end
        else if (alt_rise) alt = 1;
      end
      p0_prev = ifc.path0_dv;
      p1_prev = ifc.path1_dv;
      if (cyc >= last_sw && cyc < last_sw + HOLD) m_pend = ho_flag;
      else m_pend = (target != m_sel);
      if (cyc == last_sw + HOLD) ho_flag = 0;
      req_prev = (target != m_sel);
    end
  end

  // Monitor: event pulses against queue heads, levels against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("switch_done", int'(ifc.switch_done),
          int'(sw_q.size() > 0 && sw_q[0].e_n == cyc));
      if (ifc.switch_done && sw_q.size() > 0 && sw_q[0].e_n == cyc)
        chk("switch_sel", int'(ifc.select), int'(sw_q[0].sel));
      chk("failover", int'(ifc.failover), int'(fo_q.size() > 0 && fo_q[0].e_n == cyc));
      while (sw_q.size() > 0 && sw_q[0].e_n <= cyc) void'(sw_q.pop_front());
      while (fo_q.size() > 0 && fo_q[0].e_n <= cyc) void'(fo_q.pop_front());
      chk("select", int'(ifc.select), int'(m_sel));
      chk("pending", int'(ifc.pending), int'(m_pend));
    end
  end

  task automatic tick(input logic dv, input logic cv, input logic cs);
    ifc.down_dv   = dv;
    ifc.cmd_valid = cv;
    ifc.cmd_sel   = cs;
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    ifc.cmd_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_select", int'(ifc.select), 0);
    chk("rst_pending", int'(ifc.pending), 0);
    chk("rst_switch_done", int'(ifc.switch_done), 0);
    chk("rst_failover", int'(ifc.failover), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int   len, gap;
  logic cv, cs;

  initial begin
    ifc.cmd_valid = 0; ifc.cmd_sel = 0; ifc.auto_en = 0;
    ifc.down_dv = 0; ifc.path0_dv = 0; ifc.path1_dv = 0;
    #2;
    do_reset();

    // Idle switch
    idle(20);
    tick(1'b0, 1'b1, 1'b1);
    idle(80);

    // Mid-frame command: 68-cycle frame, command at byte 10
    for (int i = 0; i < 68; i++) tick(1'b1, i == 10, !m_sel);
    idle(90);

    // Cancel inside a frame
    for (int i = 0; i < 40; i++) begin
      cs = (i == 5) ? !m_sel : m_sel;
      tick(1'b1, i == 5 || i == 20, cs);
    end
    idle(30);

    // Hold-off: switch then immediate revert request
    tick(1'b0, 1'b1, !m_sel);
    idle(10);
    tick(1'b0, 1'b1, !m_sel);
    idle(120);

    // Randomized frames and commands
    for (int it = 0; it < 250; it++) begin
      len = $urandom_range(60, 1);
      gap = $urandom_range(30, 0);
      for (int i = 0; i < len + gap; i++) begin
        cv = ($urandom_range(11, 0) == 0);
        cs = 1'($urandom_range(1, 0));
        tick(i < len, cv, cs);
      end
    end
    idle(100);

    // Failover: path0 silent, path1 busy, with and without auto_en
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      ifc.auto_en = (pass == 0);
      for (int i = 0; i < 1300; i++) begin
        ifc.path1_dv = ((i % 72) < 60);
        tick(1'b0, 1'b0, 1'b0);
      end
      ifc.path1_dv = 0;
      ifc.auto_en  = 0;
      chk("failover_select", int'(ifc.select), int'(WdOn && pass == 0));
    end

    // Reset while pending mid-frame, then an idle switch
    do_reset();
    idle(20);
    tick(1'b0, 1'b1, 1'b1);
    idle(80);
    for (int i = 0; i < 16; i++) tick(1'b1, i == 5, 1'b0);
    chk("pre_rst_pending", int'(ifc.pending), 1);
    do_reset();
    idle(20);
    tick(1'b0, 1'b1, 1'b1);
    idle(5);
    chk("post_rst_select", int'(ifc.select), 1);
    idle(80);

    chk("sw_queue_drained", sw_q.size(), 0);
    chk("fo_queue_drained", fo_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
